// File: rtl/sop_scan_pkg.sv
// Shared encodings and widths for the SOP exhaustive truth-table scanner.
package sop_scan_pkg;

    localparam int unsigned N_IN  = 4;
    localparam int unsigned TT_W  = 16;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned TMR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/sop_scan_settle_timer.sv
// Loadable settle down-counter; expired pulses on the last settle cycle of a vector.
module sop_scan_settle_timer
    import sop_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    logic [TMR_W-1:0] cnt;
    logic [TMR_W-1:0] cnt_d;

    // Load sets the full hold count; otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt;
        if (load) begin
            cnt_d = TMR_W'(SETTLE_CYCLES);
        end else if (cnt != '0) begin
            cnt_d = cnt - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            expired <= (cnt_d == TMR_W'(1));
        end
    end

endmodule

// File: rtl/sop_exhaustive_scanner.sv
// Walks the SOP block through all 16 input vectors, captures F into a truth table
// and scores it against the expected table latched at start.
module sop_exhaustive_scanner
    import sop_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TT_W-1:0]   expected_tt,
    output logic [N_IN-1:0]   abcd,
    input  logic              f_in,
    output logic              busy,
    output logic              done,
    output logic [TT_W-1:0]   tt_out,
    output logic              match,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [N_IN-1:0]   first_fail_idx
);

    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TT_W - 1);

    scan_state_e       state_q;
    scan_state_e       state_d;
    logic [N_IN-1:0]   idx;
    logic [TT_W-1:0]   exp_q;
    logic              timer_load;
    logic              timer_expired;
    logic              sample_miss;

    sop_scan_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; the settle timer reloads on every entry into SETTLE.
    always_comb begin
        state_d     = state_q;
        timer_load  = 1'b0;
        sample_miss = (f_in != exp_q[idx]);
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
            end
            SETTLE: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (idx == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d    = SETTLE;
                    timer_load = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs, updated on the same edges as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abcd           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            tt_out         <= '0;
            match          <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
            idx            <= '0;
            exp_q          <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    abcd <= '0;
                    if (start) begin
                        exp_q          <= expected_tt;
                        tt_out         <= '0;
                        mismatch_count <= '0;
                        first_fail_idx <= '0;
                        match          <= 1'b0;
                        idx            <= '0;
                        busy           <= 1'b1;
                    end
                end
                SETTLE: begin
                    abcd <= idx;
                end
                SAMPLE: begin
                    tt_out[idx] <= f_in;
                    if (sample_miss) begin
                        mismatch_count <= mismatch_count + CNT_W'(1);
                        if (mismatch_count == '0) begin
                            first_fail_idx <= idx;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        // Final verdict folds in this last sample.
                        done  <= 1'b1;
                        match <= !sample_miss && (mismatch_count == '0);
                        abcd  <= '0;
                    end else begin
                        idx  <= idx + N_IN'(1);
                        abcd <= idx + N_IN'(1);
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    idx  <= '0;
                    abcd <= '0;
                end
                default: begin
                    busy <= 1'b0;
                    abcd <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sop_exhaustive_scanner.sv
// Directed bench for sop_exhaustive_scanner with a scoreboard of predicted scan results.
module tb_sop_exhaustive_scanner;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] expected_tt;
    logic [3:0]  abcd;
    logic        f_in;
    logic        busy;
    logic        done;
    logic [15:0] tt_out;
    logic        match;
    logic [4:0]  mismatch_count;
    logic [3:0]  first_fail_idx;

    logic [15:0] tt_model;
    int          cyc;
    int          tests;
    int          fails;

    typedef struct {
        logic [15:0] tt;
        logic        m;
        logic [4:0]  cnt;
        logic [3:0]  ffi;
    } exp_t;

    exp_t sb[$];

    sop_exhaustive_scanner #(.SETTLE_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .expected_tt    (expected_tt),
        .abcd           (abcd),
        .f_in           (f_in),
        .busy           (busy),
        .done           (done),
        .tt_out         (tt_out),
        .match          (match),
        .mismatch_count (mismatch_count),
        .first_fail_idx (first_fail_idx)
    );

    assign f_in = tt_model[abcd];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t predict(input logic [15:0] m, input logic [15:0] e);
        exp_t r;
        r.tt  = m;
        r.cnt = '0;
        r.ffi = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i] != e[i]) begin
                r.cnt = r.cnt + 5'd1;
                r.ffi = 4'(i);
            end
        end
        r.m = (m == e);
        return r;
    endfunction

    // Called one time unit after a rising edge with the DUT idle.
    task automatic do_scan(input logic [15:0] model, input logic [15:0] exp_tt, input bit disturb);
        int   t;
        int   done_at;
        exp_t e;
        tt_model    = model;
        expected_tt = exp_tt;
        sb.push_back(predict(model, exp_tt));
        start = 1'b1;
        t = cyc;
        done_at = -1;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (disturb && k == 16) begin
                chk("abcd_at_disturb", 32'(abcd), 32'd5);
                start = 1'b1;
                expected_tt = ~exp_tt;
            end
            if (disturb && k == 18) begin
                start = 1'b0;
                expected_tt = exp_tt;
            end
            if (k <= 49) begin
                chk("abcd_seq", 32'(abcd), (k <= 48) ? 32'((k - 1) / 3) : 32'd0);
                chk("busy_scan", 32'(busy), 32'd1);
            end
            if (done === 1'b1) done_at = cyc;
        end
        chk("done_cycle", 32'(done_at), 32'(t + 49));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("tt_out", 32'(tt_out), 32'(e.tt));
            chk("match", 32'(match), 32'(e.m));
            chk("mismatch_count", 32'(mismatch_count), 32'(e.cnt));
            chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
        end else begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end
        @(posedge clk);
        #1;
        chk("done_pulse_end", 32'(done), 32'd0);
        chk("busy_after", 32'(busy), 32'd0);
        chk("abcd_after", 32'(abcd), 32'd0);
        chk("hold_tt_out", 32'(tt_out), 32'(model));
    endtask

    initial begin
        int t;
        tests       = 0;
        fails       = 0;
        rst         = 1'b0;
        start       = 1'b0;
        expected_tt = '0;
        tt_model    = '0;

        // Reset asserted mid-clock, checked before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_abcd", 32'(abcd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tt_out", 32'(tt_out), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        repeat (3) @(posedge clk);
        #4 rst = 1'b0;
        @(posedge clk);
        #1;

        do_scan(16'hF0F0, 16'hF0F0, 1'b0);
        do_scan(16'hF0F1, 16'hF0F0, 1'b0);
        do_scan(16'h0000, 16'h8010, 1'b0);
        do_scan(16'h1234, 16'h1234, 1'b1);

        // Reset in the middle of vector 7 aborts the scan.
        tt_model    = 16'hFFFF;
        expected_tt = 16'h0000;
        start = 1'b1;
        t = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        chk("abort_cycle", 32'(cyc), 32'(t + 22));
        chk("abort_abcd_pre", 32'(abcd), 32'd7);
        #4 rst = 1'b1;
        #1;
        chk("abort_abcd", 32'(abcd), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tt_out", 32'(tt_out), 32'd0);
        chk("abort_mcount", 32'(mismatch_count), 32'd0);
        chk("abort_ffi", 32'(first_fail_idx), 32'd0);
        chk("abort_match", 32'(match), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", 32'(done), 32'd0);
        end
        #4 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_abcd", 32'(abcd), 32'd0);

        do_scan(16'hA5C3, 16'hA5C3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
